demux_14_seq: RTL

- Registered 1-to-4 stream demultiplexer: the inverse of the team's 4:1 select mux.
- Accepts one input word per cycle over a valid/ready handshake and steers it by select bits s1,s2 to one of four output channels a,b,c,d.
- Each channel has its own 2-entry FIFO with valid/ready, so a stalled channel does not block words bound for other channels.
- Sits between a single producer and four independent consumers.

---
 rtl/demux_14_seq.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/demux_14_seq.sv
// -----------------------------------------------------------------------------
// demux_14_seq
//
// Registered 1-to-4 stream demultiplexer. One input word per cycle is steered
// by {s1,s2} into one of four channels (00->a, 01->b, 10->c, 11->d). Each
// channel owns a 2-entry FIFO, so a stalled consumer only blocks words that are
// bound for its own channel.
//
// Handshake (all ports): a transfer happens on a rising clk edge where valid
// and ready are both 1. valid never depends on ready. in_ready depends only on
// {s1,s2} and the selected FIFO fill level, never on in_valid or on any
// channel ready input.
//
// Ports:
//   clk                      rising-edge clock
//   rst_n                    asynchronous active-low reset
//   s1, s2                   channel select (MSB, LSB), sampled with din
//   din [WIDTH-1:0]          input word
//   in_valid                 din/s1/s2 valid
//   in_ready                 selected channel FIFO has room
//   a, b, c, d [WIDTH-1:0]   channel FIFO head
//   a_valid .. d_valid       channel FIFO non-empty
//   a_ready .. d_ready       consumer takes channel head
//   ovf_cnt [7:0]            stalled-input cycle count, saturates at 255
// -----------------------------------------------------------------------------

// Two-entry FIFO used once per channel. The caller only asserts push when
// not_full is 1, so there is no overflow guard here.
module demux_14_seq_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             not_full
);
    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             pop;

    // A ready with nothing buffered is simply ignored.
    assign pop      = ready && (count_q != 2'd0);
    assign valid    = (count_q != 2'd0);
    assign not_full = (count_q != 2'd2);
    assign dout     = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            // Push and pop together leave the fill level unchanged.
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

module demux_14_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s1,
    input  logic             s2,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             a_valid,
    output logic             b_valid,
    output logic             c_valid,
    output logic             d_valid,
    input  logic             a_ready,
    input  logic             b_ready,
    input  logic             c_ready,
    input  logic             d_ready,
    output logic [7:0]       ovf_cnt
);
    logic [1:0] sel;
    logic [3:0] not_full;   // index 0..3 = channel a..d
    logic [3:0] push;
    logic       accept;
    logic       stall;
    logic [7:0] ovf_cnt_q;

    assign sel = {s1, s2};

    // Room in the selected channel only; no pass-through when it is full.
    always_comb begin
        in_ready = 1'b0;
        case (sel)
            2'b00:   in_ready = not_full[0];
            2'b01:   in_ready = not_full[1];
            2'b10:   in_ready = not_full[2];
            default: in_ready = not_full[3];
        endcase
    end

    assign accept = in_valid && in_ready;
    assign stall  = in_valid && !in_ready;

    // Only the selected FIFO sees a write.
    always_comb begin
        push = 4'b0000;
        if (accept) begin
            push[sel] = 1'b1;
        end
    end

    demux_14_seq_fifo #(.WIDTH(WIDTH)) u_fifo_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push[0]),
        .din      (din),
        .ready    (a_ready),
        .dout     (a),
        .valid    (a_valid),
        .not_full (not_full[0])
    );

    demux_14_seq_fifo #(.WIDTH(WIDTH)) u_fifo_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push[1]),
        .din      (din),
        .ready    (b_ready),
        .dout     (b),
        .valid    (b_valid),
        .not_full (not_full[1])
    );

    demux_14_seq_fifo #(.WIDTH(WIDTH)) u_fifo_c (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push[2]),
        .din      (din),
        .ready    (c_ready),
        .dout     (c),
        .valid    (c_valid),
        .not_full (not_full[2])
    );

    demux_14_seq_fifo #(.WIDTH(WIDTH)) u_fifo_d (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push[3]),
        .din      (din),
        .ready    (d_ready),
        .dout     (d),
        .valid    (d_valid),
        .not_full (not_full[3])
    );

    // Stalled-cycle counter, sticks at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= 8'd0;
        end else if (stall && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
endmodule
